// File: rtl/axi_ram_slave.sv
`timescale 1ns/1ps
// axi_ram_slave
//   AXI4 slave backed by MEM_WORDS x 32-bit words mapped at BASE_ADDR.
//   Bursts are always INCR with 4-byte beats. Out-of-range write beats are
//   dropped, and out-of-range read beats return zero with SLVERR. The write
//   and read channels run independent state machines.
//
// Ports
//   clk, rst              : clock, asynchronous active-high reset
//   axi_aw* / axi_w*      : write address and write data channels (slave side)
//   axi_b*                : write response channel
//   axi_ar* / axi_r*      : read address and read data channels
module axi_ram_slave #(
  parameter int          MEM_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  axi_awid,
  input  logic [31:0] axi_awaddr,
  input  logic [7:0]  axi_awlen,
  input  logic        axi_awvalid,
  output logic        axi_awready,
  input  logic [31:0] axi_wdata,
  input  logic [3:0]  axi_wstrb,
  input  logic        axi_wlast,
  input  logic        axi_wvalid,
  output logic        axi_wready,
  output logic [3:0]  axi_bid,
  output logic [1:0]  axi_bresp,
  output logic        axi_bvalid,
  input  logic        axi_bready,
  input  logic [3:0]  axi_arid,
  input  logic [31:0] axi_araddr,
  input  logic [7:0]  axi_arlen,
  input  logic        axi_arvalid,
  output logic        axi_arready,
  output logic [3:0]  axi_rid,
  output logic [31:0] axi_rdata,
  output logic [1:0]  axi_rresp,
  output logic        axi_rlast,
  output logic        axi_rvalid,
  input  logic        axi_rready
);

  localparam int          IDX_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [29:0] BASE_WORD = BASE_ADDR[31:2];

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;

  logic [31:0] mem [MEM_WORDS];

  w_state_t    w_state, w_next;
  logic [3:0]  aw_id_q;
  logic [29:0] aw_word_q;
  logic [7:0]  aw_len_q;
  logic [7:0]  w_cnt;
  logic        w_err;
  logic [29:0] w_word, w_off;
  logic        w_oor, w_beat_last, w_hs;

  r_state_t    r_state, r_next;
  logic [3:0]  ar_id_q;
  logic [29:0] ar_word_q;
  logic [7:0]  ar_len_q;
  logic [7:0]  r_cnt;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;
  logic        rlast_q;
  logic [29:0] r_word, r_off;
  logic        r_oor;

  // Byte-lane bits of the start addresses are ignored; every beat is a full word.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{axi_awaddr[1:0], axi_araddr[1:0]};

  // Addresses are tracked as word addresses, so the range check below works
  // on a word offset from the base; a start below the base wraps to a huge
  // offset, but it is also caught explicitly.
  assign w_word      = aw_word_q + {22'd0, w_cnt};
  assign w_off       = w_word - BASE_WORD;
  assign w_oor       = (w_word < BASE_WORD) || ({2'b00, w_off} >= 32'(MEM_WORDS));
  assign w_beat_last = (w_cnt == aw_len_q);
  assign w_hs        = (w_state == W_DATA) && axi_wvalid;

  assign r_word = ar_word_q + {22'd0, r_cnt};
  assign r_off  = r_word - BASE_WORD;
  assign r_oor  = (r_word < BASE_WORD) || ({2'b00, r_off} >= 32'(MEM_WORDS));

  // Write FSM next state and handshake outputs. The FSM leaves W_DATA on
  // its own beat count, so a bad wlast is only recorded in the error flag.
  always_comb begin
    w_next      = w_state;
    axi_awready = 1'b0;
    axi_wready  = 1'b0;
    axi_bvalid  = 1'b0;
    case (w_state)
      W_IDLE: begin
        axi_awready = 1'b1;
        if (axi_awvalid) w_next = W_DATA;
      end
      W_DATA: begin
        axi_wready = 1'b1;
        if (axi_wvalid && w_beat_last) w_next = W_RESP;
      end
      W_RESP: begin
        axi_bvalid = 1'b1;
        if (axi_bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  // Write state register, AW capture, beat counting and sticky error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state   <= W_IDLE;
      aw_id_q   <= 4'd0;
      aw_word_q <= 30'd0;
      aw_len_q  <= 8'd0;
      w_cnt     <= 8'd0;
      w_err     <= 1'b0;
    end else begin
      w_state <= w_next;
      if (w_state == W_IDLE && axi_awvalid) begin
        aw_id_q   <= axi_awid;
        aw_word_q <= axi_awaddr[31:2];
        aw_len_q  <= axi_awlen;
        w_cnt     <= 8'd0;
        w_err     <= 1'b0;
      end
      if (w_hs) begin
        w_cnt <= w_cnt + 8'd1;
        if (w_oor || (axi_wlast != w_beat_last)) w_err <= 1'b1;
      end
    end
  end

  // Storage array: no reset, so data survives a reset. Each byte lane is
  // written only when its strobe is set.
  always_ff @(posedge clk) begin
    if (w_hs && !w_oor) begin
      for (int b = 0; b < 4; b++) begin
        if (axi_wstrb[b]) mem[w_off[IDX_W-1:0]][8*b +: 8] <= axi_wdata[8*b +: 8];
      end
    end
  end

  assign axi_bid   = aw_id_q;
  assign axi_bresp = w_err ? 2'b10 : 2'b00;

  // Read FSM next state and handshake outputs. Each beat goes through a
  // fetch cycle, so back-to-back beats take at least two cycles.
  always_comb begin
    r_next      = r_state;
    axi_arready = 1'b0;
    axi_rvalid  = 1'b0;
    case (r_state)
      R_IDLE: begin
        axi_arready = 1'b1;
        if (axi_arvalid) r_next = R_FETCH;
      end
      R_FETCH: r_next = R_DATA;
      R_DATA: begin
        axi_rvalid = 1'b1;
        if (axi_rready) r_next = rlast_q ? R_IDLE : R_FETCH;
      end
      default: r_next = R_IDLE;
    endcase
  end

  // Read state register and beat payload. The payload is registered during
  // the fetch cycle, so a write that lands on the same word in the same
  // cycle is not yet visible: the read sees the old contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= R_IDLE;
      ar_id_q   <= 4'd0;
      ar_word_q <= 30'd0;
      ar_len_q  <= 8'd0;
      r_cnt     <= 8'd0;
      rdata_q   <= 32'd0;
      rresp_q   <= 2'b00;
      rlast_q   <= 1'b0;
    end else begin
      r_state <= r_next;
      if (r_state == R_IDLE && axi_arvalid) begin
        ar_id_q   <= axi_arid;
        ar_word_q <= axi_araddr[31:2];
        ar_len_q  <= axi_arlen;
        r_cnt     <= 8'd0;
      end
      if (r_state == R_FETCH) begin
        rdata_q <= r_oor ? 32'd0 : mem[r_off[IDX_W-1:0]];
        rresp_q <= r_oor ? 2'b10 : 2'b00;
        rlast_q <= (r_cnt == ar_len_q);
      end
      if (r_state == R_DATA && axi_rready && !rlast_q) r_cnt <= r_cnt + 8'd1;
    end
  end

  assign axi_rid   = ar_id_q;
  assign axi_rdata = rdata_q;
  assign axi_rresp = rresp_q;
  assign axi_rlast = rlast_q;

endmodule

// File: tb/tb_axi_ram_slave.sv
`timescale 1ns/1ps
// tb_axi_ram_slave
//   Self-checking bench for axi_ram_slave. A word-array model of the RAM is
//   updated from the address-range rules and byte strobes. The bench
//   compares every response and read beat against that model.
module tb_axi_ram_slave;

  localparam int          MEM_WORDS = 64;
  localparam logic [31:0] BASE      = 32'h0000_1000;
  localparam int          MAX_WAIT  = 200;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  axi_awid = '0;
  logic [31:0] axi_awaddr = '0;
  logic [7:0]  axi_awlen = '0;
  logic        axi_awvalid = 1'b0;
  logic        axi_awready;
  logic [31:0] axi_wdata = '0;
  logic [3:0]  axi_wstrb = '0;
  logic        axi_wlast = 1'b0;
  logic        axi_wvalid = 1'b0;
  logic        axi_wready;
  logic [3:0]  axi_bid;
  logic [1:0]  axi_bresp;
  logic        axi_bvalid;
  logic        axi_bready = 1'b0;
  logic [3:0]  axi_arid = '0;
  logic [31:0] axi_araddr = '0;
  logic [7:0]  axi_arlen = '0;
  logic        axi_arvalid = 1'b0;
  logic        axi_arready;
  logic [3:0]  axi_rid;
  logic [31:0] axi_rdata;
  logic [1:0]  axi_rresp;
  logic        axi_rlast;
  logic        axi_rvalid;
  logic        axi_rready = 1'b0;

  axi_ram_slave #(.MEM_WORDS(MEM_WORDS), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst),
    .axi_awid(axi_awid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rid(axi_rid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
    .axi_rlast(axi_rlast), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] model_mem [MEM_WORDS];
  logic [31:0] wr_data [256];
  logic [3:0]  wr_strb [256];

  logic [31:0] rd_data_q [$];
  logic [1:0]  rd_resp_q [$];
  logic        rd_last_q [$];
  logic [3:0]  rd_id_q   [$];
  int          rd_first_latency;
  bit          rd_stable;
  bit          b_prompt;
  bit          b_stable;

  // A beat is in range when its word-aligned byte address lies inside
  // [BASE, BASE + 4*MEM_WORDS).
  function automatic bit addr_in_range(input logic [31:0] a);
    longint unsigned aa = longint'(a & 32'hFFFF_FFFC);
    longint unsigned bb = longint'(BASE);
    return (aa >= bb) && ((aa - bb) < longint'(4 * MEM_WORDS));
  endfunction

  // Apply a burst held in wr_data/wr_strb to the model and return the
  // response the slave owes for it.
  function automatic logic [1:0] model_write(input logic [31:0] addr, input int len, input int last_beat);
    bit err = 1'b0;
    for (int k = 0; k <= len; k++) begin
      logic [31:0] a = addr + 32'(4 * k);
      if (!addr_in_range(a)) err = 1'b1;
      else begin
        int idx = int'((a - BASE) >> 2);
        for (int b = 0; b < 4; b++)
          if (wr_strb[k][b]) model_mem[idx][8*b +: 8] = wr_data[k][8*b +: 8];
      end
      if ((k == last_beat) != (k == len)) err = 1'b1;
    end
    return err ? 2'b10 : 2'b00;
  endfunction

  function automatic void model_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
    if (addr_in_range(a)) begin
      d = model_mem[int'((a - BASE) >> 2)];
      r = 2'b00;
    end else begin
      d = 32'h0;
      r = 2'b10;
    end
  endfunction

  // Drive one write burst from wr_data/wr_strb. wlast is raised on beat
  // last_beat, and bready is held low for hold cycles once bvalid is up.
  task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                           input int last_beat, input int hold,
                           output logic [3:0] got_bid, output logic [1:0] got_bresp);
    int cyc;
    @(negedge clk);
    axi_awid = id; axi_awaddr = addr; axi_awlen = 8'(len); axi_awvalid = 1'b1;
    cyc = 0;
    while (!axi_awready && cyc < MAX_WAIT) begin @(negedge clk); cyc++; end
    if (cyc >= MAX_WAIT) begin checks++; errors++; $display("[TB] FAIL aw_timeout: awready low for %0d cycles", cyc); end
    @(negedge clk);
    axi_awvalid = 1'b0;
    for (int k = 0; k <= len; k++) begin
      axi_wdata = wr_data[k]; axi_wstrb = wr_strb[k]; axi_wlast = (k == last_beat); axi_wvalid = 1'b1;
      cyc = 0;
      while (!axi_wready && cyc < MAX_WAIT) begin @(negedge clk); cyc++; end
      if (cyc >= MAX_WAIT) begin checks++; errors++; $display("[TB] FAIL w_timeout: beat %0d wready low", k); end
      @(negedge clk);
    end
    axi_wvalid = 1'b0; axi_wlast = 1'b0;
    b_prompt = axi_bvalid; got_bid = axi_bid; got_bresp = axi_bresp; b_stable = 1'b1;
    for (int d = 0; d < hold; d++) begin
      @(negedge clk);
      if (!axi_bvalid || axi_bid !== got_bid || axi_bresp !== got_bresp) b_stable = 1'b0;
    end
    axi_bready = 1'b1;
    cyc = 0;
    while (!axi_bvalid && cyc < MAX_WAIT) begin @(negedge clk); cyc++; end
    if (cyc >= MAX_WAIT) begin checks++; errors++; $display("[TB] FAIL b_timeout: bvalid low for %0d cycles", cyc); end
    got_bid = axi_bid; got_bresp = axi_bresp;
    @(negedge clk);
    axi_bready = 1'b0;
  endtask

  // Drive one read burst and collect each beat into the rd_* queues. rready
  // is held low for hold cycles per beat, and payload stability is tracked.
  task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input int len, input int hold);
    int cyc;
    rd_data_q.delete(); rd_resp_q.delete(); rd_last_q.delete(); rd_id_q.delete();
    @(negedge clk);
    axi_arid = id; axi_araddr = addr; axi_arlen = 8'(len); axi_arvalid = 1'b1;
    cyc = 0;
    while (!axi_arready && cyc < MAX_WAIT) begin @(negedge clk); cyc++; end
    if (cyc >= MAX_WAIT) begin checks++; errors++; $display("[TB] FAIL ar_timeout: arready low for %0d cycles", cyc); end
    @(negedge clk);
    axi_arvalid = 1'b0;
    rd_first_latency = 1; rd_stable = 1'b1;
    for (int k = 0; k <= len; k++) begin
      logic [31:0] d; logic [1:0] r; logic l; logic [3:0] i;
      cyc = 0;
      while (!axi_rvalid && cyc < MAX_WAIT) begin
        @(negedge clk); cyc++;
        if (k == 0) rd_first_latency++;
      end
      if (cyc >= MAX_WAIT) begin checks++; errors++; $display("[TB] FAIL r_timeout: beat %0d rvalid low", k); end
      d = axi_rdata; r = axi_rresp; l = axi_rlast; i = axi_rid;
      rd_data_q.push_back(d); rd_resp_q.push_back(r); rd_last_q.push_back(l); rd_id_q.push_back(i);
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        if (!axi_rvalid || axi_rdata !== d || axi_rresp !== r || axi_rlast !== l || axi_rid !== i) rd_stable = 1'b0;
      end
      axi_rready = 1'b1;
      @(negedge clk);
      axi_rready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({axi_awready, axi_arready, axi_wready, axi_bvalid, axi_rvalid, axi_rlast} !== 6'b110000) begin
      errors++; $display("[TB] FAIL reset_handshake: got %b expected 110000",
        {axi_awready, axi_arready, axi_wready, axi_bvalid, axi_rvalid, axi_rlast});
    end
    checks++;
    if ({axi_bresp, axi_rresp, axi_bid, axi_rid} !== 12'h000) begin
      errors++; $display("[TB] FAIL reset_ids_resp: got %h expected 000", {axi_bresp, axi_rresp, axi_bid, axi_rid});
    end
    checks++;
    if (axi_rdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_rdata: got %h expected 0", axi_rdata); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Give the whole memory known contents so later reads can be predicted.
  task automatic test_fill();
    logic [3:0] gid; logic [1:0] gresp, eresp;
    for (int k = 0; k < MEM_WORDS; k++) begin wr_data[k] = $urandom; wr_strb[k] = 4'hF; end
    eresp = model_write(BASE, MEM_WORDS - 1, MEM_WORDS - 1);
    axi_write(4'h3, BASE, MEM_WORDS - 1, MEM_WORDS - 1, 0, gid, gresp);
    checks++;
    if (gresp !== eresp || gid !== 4'h3) begin
      errors++; $display("[TB] FAIL fill_resp: got bresp %b bid %h expected %b 3", gresp, gid, eresp);
    end
  endtask

  task automatic test_single_write();
    logic [3:0] gid; logic [1:0] gresp, eresp;
    wr_data[0] = 32'hDEADBEEF; wr_strb[0] = 4'hF;
    eresp = model_write(BASE + 32'h10, 0, 0);
    axi_write(4'h5, BASE + 32'h10, 0, 0, 0, gid, gresp);
    checks++;
    if (b_prompt !== 1'b1) begin errors++; $display("[TB] FAIL single_bvalid_timing: got %b expected 1", b_prompt); end
    checks++;
    if (gresp !== 2'b00 || eresp !== 2'b00) begin errors++; $display("[TB] FAIL single_bresp: got %b expected 00", gresp); end
    checks++;
    if (gid !== 4'h5) begin errors++; $display("[TB] FAIL single_bid: got %h expected 5", gid); end
  endtask

  task automatic test_single_read();
    axi_read(4'h9, BASE + 32'h10, 0, 0);
    checks++;
    if (rd_first_latency != 2) begin errors++; $display("[TB] FAIL single_read_latency: got %0d expected 2", rd_first_latency); end
    checks++;
    if (rd_data_q[0] !== 32'hDEADBEEF || rd_resp_q[0] !== 2'b00 || rd_last_q[0] !== 1'b1 || rd_id_q[0] !== 4'h9) begin
      errors++; $display("[TB] FAIL single_read_beat: got %h/%b/%b/%h expected deadbeef/00/1/9",
        rd_data_q[0], rd_resp_q[0], rd_last_q[0], rd_id_q[0]);
    end
  endtask

  task automatic test_incr_strobe();
    logic [3:0] gid; logic [1:0] gresp, eresp;
    logic [31:0] exp_words [4];
    exp_words[0] = 32'h1; exp_words[1] = 32'h2; exp_words[2] = 32'hFFFFFF03; exp_words[3] = 32'h4;
    for (int k = 0; k < 4; k++) begin wr_data[k] = 32'hFFFFFFFF; wr_strb[k] = 4'hF; end
    eresp = model_write(BASE + 32'h40, 3, 3);
    axi_write(4'h1, BASE + 32'h40, 3, 3, 0, gid, gresp);
    for (int k = 0; k < 4; k++) begin wr_data[k] = 32'(k + 1); wr_strb[k] = (k == 2) ? 4'h1 : 4'hF; end
    eresp = model_write(BASE + 32'h40, 3, 3);
    axi_write(4'h2, BASE + 32'h40, 3, 3, 0, gid, gresp);
    checks++;
    if (gresp !== 2'b00 || gid !== 4'h2) begin errors++; $display("[TB] FAIL incr_bresp: got %b/%h expected 00/2", gresp, gid); end
    axi_read(4'hA, BASE + 32'h40, 3, 0);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (rd_data_q[k] !== exp_words[k] || rd_last_q[k] !== (k == 3) || rd_resp_q[k] !== 2'b00) begin
        errors++; $display("[TB] FAIL incr_beat%0d: got %h last %b resp %b expected %h last %b resp 00",
          k, rd_data_q[k], rd_last_q[k], rd_resp_q[k], exp_words[k], (k == 3));
      end
    end
  endtask

  task automatic test_out_of_range();
    logic [3:0] gid; logic [1:0] gresp, eresp, er;
    logic [31:0] ed;
    wr_data[0] = 32'hA5A5_5A5A; wr_strb[0] = 4'hF;
    eresp = model_write(BASE + 32'(4 * MEM_WORDS), 0, 0);
    axi_write(4'h6, BASE + 32'(4 * MEM_WORDS), 0, 0, 0, gid, gresp);
    checks++;
    if (gresp !== 2'b10 || eresp !== 2'b10) begin errors++; $display("[TB] FAIL oor_write_bresp: got %b expected 10", gresp); end
    // Word 0 must not have been hit by an aliased out-of-range write.
    model_read(BASE, ed, er);
    axi_read(4'h6, BASE, 0, 0);
    checks++;
    if (rd_data_q[0] !== ed) begin errors++; $display("[TB] FAIL oor_no_alias: got %h expected %h", rd_data_q[0], ed); end
    axi_read(4'h7, BASE + 32'(4 * MEM_WORDS), 0, 0);
    checks++;
    if (rd_data_q[0] !== 32'h0 || rd_resp_q[0] !== 2'b10) begin
      errors++; $display("[TB] FAIL oor_read_high: got %h/%b expected 0/10", rd_data_q[0], rd_resp_q[0]);
    end
    axi_read(4'h7, BASE - 32'h4, 0, 0);
    checks++;
    if (rd_data_q[0] !== 32'h0 || rd_resp_q[0] !== 2'b10) begin
      errors++; $display("[TB] FAIL oor_read_low: got %h/%b expected 0/10", rd_data_q[0], rd_resp_q[0]);
    end
    // Read that runs off the top: the first beat is valid, the second is an error.
    model_read(BASE + 32'(4 * (MEM_WORDS - 1)), ed, er);
    axi_read(4'h8, BASE + 32'(4 * (MEM_WORDS - 1)), 1, 0);
    checks++;
    if (rd_data_q[0] !== ed || rd_resp_q[0] !== 2'b00 || rd_resp_q[1] !== 2'b10 || rd_data_q[1] !== 32'h0) begin
      errors++; $display("[TB] FAIL oor_cross_read: got %h/%b %h/%b expected %h/00 0/10",
        rd_data_q[0], rd_resp_q[0], rd_data_q[1], rd_resp_q[1], ed);
    end
    // wlast on beat 0 of a 2-beat burst.
    wr_data[0] = 32'h1111_2222; wr_data[1] = 32'h3333_4444; wr_strb[0] = 4'hF; wr_strb[1] = 4'hF;
    eresp = model_write(BASE + 32'h80, 1, 0);
    axi_write(4'hB, BASE + 32'h80, 1, 0, 0, gid, gresp);
    checks++;
    if (gresp !== 2'b10 || eresp !== 2'b10) begin errors++; $display("[TB] FAIL early_wlast_bresp: got %b expected 10", gresp); end
  endtask

  task automatic test_backpressure();
    logic [3:0] gid; logic [1:0] gresp, eresp, er;
    logic [31:0] ed;
    wr_data[0] = $urandom; wr_strb[0] = 4'hF;
    eresp = model_write(BASE + 32'h20, 0, 0);
    axi_write(4'hC, BASE + 32'h20, 0, 0, 5, gid, gresp);
    checks++;
    if (b_stable !== 1'b1 || gresp !== eresp || gid !== 4'hC) begin
      errors++; $display("[TB] FAIL b_backpressure: stable %b bresp %b bid %h expected 1 %b c", b_stable, gresp, gid, eresp);
    end
    axi_read(4'hD, BASE + 32'h1C, 2, 5);
    checks++;
    if (rd_stable !== 1'b1) begin errors++; $display("[TB] FAIL r_backpressure_stable: got %b expected 1", rd_stable); end
    for (int k = 0; k < 3; k++) begin
      model_read(BASE + 32'h1C + 32'(4 * k), ed, er);
      checks++;
      if (rd_data_q[k] !== ed || rd_resp_q[k] !== er) begin
        errors++; $display("[TB] FAIL r_backpressure_beat%0d: got %h/%b expected %h/%b", k, rd_data_q[k], rd_resp_q[k], ed, er);
      end
    end
  endtask

  // A write beat and a read fetch of the same word in the same cycle: the
  // read must return the data from before the write.
  task automatic test_same_cycle();
    logic [3:0] gid; logic [1:0] gresp, eresp, er;
    logic [31:0] old_d, new_d;
    model_read(BASE + 32'h30, old_d, er);
    wr_data[0] = ~old_d; wr_strb[0] = 4'hF;
    eresp = model_write(BASE + 32'h30, 0, 0);
    fork
      axi_write(4'h4, BASE + 32'h30, 0, 0, 0, gid, gresp);
      axi_read(4'h4, BASE + 32'h30, 0, 0);
    join
    checks++;
    if (rd_data_q[0] !== old_d) begin errors++; $display("[TB] FAIL same_cycle_old: got %h expected %h", rd_data_q[0], old_d); end
    model_read(BASE + 32'h30, new_d, er);
    axi_read(4'h4, BASE + 32'h30, 0, 0);
    checks++;
    if (rd_data_q[0] !== new_d || gresp !== eresp) begin
      errors++; $display("[TB] FAIL same_cycle_new: got %h/%b expected %h/%b", rd_data_q[0], gresp, new_d, eresp);
    end
  endtask

  task automatic test_random();
    logic [3:0] gid, id; logic [1:0] gresp, eresp, er;
    logic [31:0] addr, ed;
    int len;
    for (int t = 0; t < 25; t++) begin
      len  = $urandom_range(0, 7);
      addr = BASE + 32'(4 * $urandom_range(0, MEM_WORDS + 3)) + 32'($urandom_range(0, 3));
      id   = 4'($urandom_range(0, 15));
      for (int k = 0; k <= len; k++) begin wr_data[k] = $urandom; wr_strb[k] = 4'($urandom_range(0, 15)); end
      eresp = model_write(addr, len, len);
      axi_write(id, addr, len, len, $urandom_range(0, 3), gid, gresp);
      checks++;
      if (gresp !== eresp || gid !== id) begin
        errors++; $display("[TB] FAIL rand%0d_b: got %b/%h expected %b/%h", t, gresp, gid, eresp, id);
      end
      id = 4'($urandom_range(0, 15));
      axi_read(id, addr, len, $urandom_range(0, 2));
      for (int k = 0; k <= len; k++) begin
        model_read(addr + 32'(4 * k), ed, er);
        checks++;
        if (rd_data_q[k] !== ed || rd_resp_q[k] !== er || rd_last_q[k] !== (k == len) || rd_id_q[k] !== id) begin
          errors++; $display("[TB] FAIL rand%0d_r%0d: got %h/%b/%b/%h expected %h/%b/%b/%h", t, k,
            rd_data_q[k], rd_resp_q[k], rd_last_q[k], rd_id_q[k], ed, er, (k == len), id);
        end
      end
    end
  endtask

  // Reset in the middle of a 4-beat read, then check a fresh read works.
  task automatic test_reset_mid_burst();
    logic [1:0] er;
    logic [31:0] ed;
    int cyc;
    @(negedge clk);
    axi_arid = 4'hE; axi_araddr = BASE + 32'h8; axi_arlen = 8'd3; axi_arvalid = 1'b1;
    cyc = 0;
    while (!axi_arready && cyc < MAX_WAIT) begin @(negedge clk); cyc++; end
    @(negedge clk);
    axi_arvalid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      cyc = 0;
      while (!axi_rvalid && cyc < MAX_WAIT) begin @(negedge clk); cyc++; end
      if (cyc >= MAX_WAIT) begin checks++; errors++; $display("[TB] FAIL mid_r_timeout: beat %0d", k); end
      if (k == 0) begin axi_rready = 1'b1; @(negedge clk); axi_rready = 1'b0; end
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({axi_rvalid, axi_arready, axi_rlast} !== 3'b010) begin
      errors++; $display("[TB] FAIL mid_reset_outputs: got %b expected 010", {axi_rvalid, axi_arready, axi_rlast});
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    axi_read(4'h2, BASE + 32'h8, 1, 0);
    for (int k = 0; k < 2; k++) begin
      model_read(BASE + 32'h8 + 32'(4 * k), ed, er);
      checks++;
      if (rd_data_q[k] !== ed || rd_resp_q[k] !== er || rd_last_q[k] !== (k == 1)) begin
        errors++; $display("[TB] FAIL post_reset_read%0d: got %h/%b/%b expected %h/%b/%b",
          k, rd_data_q[k], rd_resp_q[k], rd_last_q[k], ed, er, (k == 1));
      end
    end
  endtask

  // Run each scenario in order, then report.
  initial begin
    test_reset();
    test_fill();
    test_single_write();
    test_single_read();
    test_incr_strobe();
    test_out_of_range();
    test_backpressure();
    test_same_cycle();
    test_random();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Safety net in case a handshake never completes.
  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

endmodule
